// File: rtl/atomic_unit_if.sv
// Signal bundle for the atomic sequencer: the pipeline request and response, the data-memory port
// and the LR/SC reservation tracker.
interface atomic_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [4:0]      funct5;
    logic            is_dword;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] src;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            misaligned;
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [1:0]      mem_size;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ready;
    logic            lr_valid;
    logic            sc_valid;
    logic [XLEN-1:0] lr_addr;
    logic [XLEN-1:0] sc_addr;
    logic            sc_success;

    modport master (
        output start, funct5, is_dword, addr, src, mem_rdata, mem_ready, sc_success,
        input  busy, done, result, misaligned, mem_req, mem_we, mem_addr, mem_wdata, mem_size,
               lr_valid, sc_valid, lr_addr, sc_addr
    );

    modport slave (
        input  start, funct5, is_dword, addr, src, mem_rdata, mem_ready, sc_success,
        output busy, done, result, misaligned, mem_req, mem_we, mem_addr, mem_wdata, mem_size,
               lr_valid, sc_valid, lr_addr, sc_addr
    );
endinterface

// File: rtl/atomic_unit.sv
// Sequencer for RV32A/RV64A atomics. It runs LR, SC and the AMO read-modify-write operations as
// multi-cycle transactions on the data-memory port.
module atomic_unit #(
    parameter int XLEN = 32
) (
    input logic          clk,
    input logic          reset,
    atomic_unit_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_COMPUTE, S_SC_CHECK, S_WRITE, S_DONE
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD, OP_SWAP, OP_LR, OP_SC, OP_XOR, OP_OR, OP_AND,
        OP_MIN, OP_MAX, OP_MINU, OP_MAXU
    } op_t;

    state_t          state, state_nx;
    op_t             op_q, op_dec;
    logic            dword_q, mis_q, dword_in, align_err, lt_s, lt_u;
    logic [XLEN-1:0] addr_q, src_q, result_q, new_q, ld_val, b_op, alu;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    // A .W store keeps only the low word; the upper bits of the write data are zero.
    function automatic logic [XLEN-1:0] store_fmt(input logic d, input logic [XLEN-1:0] v);
        return d ? v : XLEN'(v[31:0]);
    endfunction

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        op_dec = OP_ADD;
        case (bus.funct5)
            5'b00001: op_dec = OP_SWAP;
            5'b00010: op_dec = OP_LR;
            5'b00011: op_dec = OP_SC;
            5'b00100: op_dec = OP_XOR;
            5'b01000: op_dec = OP_OR;
            5'b01100: op_dec = OP_AND;
            5'b10000: op_dec = OP_MIN;
            5'b10100: op_dec = OP_MAX;
            5'b11000: op_dec = OP_MINU;
            5'b11100: op_dec = OP_MAXU;
            default:  op_dec = OP_ADD;
        endcase
    end

    assign dword_in  = bus.is_dword && (XLEN == 64);
    assign align_err = dword_in ? (bus.addr[2:0] != 3'b000) : (bus.addr[1:0] != 2'b00);
    assign ld_val    = dword_q ? bus.mem_rdata : sext32(bus.mem_rdata[31:0]);

    // result_q already holds the sign-extended old value. Sign-extending src the same way lets one
    // XLEN-wide compare serve both .W and .D, signed and unsigned.
    assign b_op = dword_q ? src_q : sext32(src_q[31:0]);
    assign lt_s = $signed(result_q) < $signed(b_op);
    assign lt_u = result_q < b_op;

    always_comb begin
        alu = result_q + b_op;
        case (op_q)
            OP_SWAP: alu = b_op;
            OP_XOR:  alu = result_q ^ b_op;
            OP_OR:   alu = result_q | b_op;
            OP_AND:  alu = result_q & b_op;
            OP_MIN:  alu = lt_s ? result_q : b_op;
            OP_MAX:  alu = lt_s ? b_op : result_q;
            OP_MINU: alu = lt_u ? result_q : b_op;
            OP_MAXU: alu = lt_u ? b_op : result_q;
            default: alu = result_q + b_op;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx       = state;
        bus.busy       = (state != S_IDLE);
        bus.done       = 1'b0;
        bus.misaligned = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.lr_valid   = 1'b0;
        bus.sc_valid   = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    if (align_err)            state_nx = S_DONE;
                    else if (op_dec == OP_SC) state_nx = S_SC_CHECK;
                    else                      state_nx = S_READ;
                end
            end
            S_READ: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ready) begin
                    bus.lr_valid = (op_q == OP_LR);
                    state_nx     = (op_q == OP_LR) ? S_DONE : S_COMPUTE;
                end
            end
            S_COMPUTE: state_nx = S_WRITE;
            S_SC_CHECK: begin
                bus.sc_valid = 1'b1;
                state_nx     = bus.sc_success ? S_WRITE : S_DONE;
            end
            S_WRITE: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = 1'b1;
                if (bus.mem_ready) state_nx = S_DONE;
            end
            S_DONE: begin
                bus.done       = 1'b1;
                bus.misaligned = mis_q;
                state_nx       = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Address, size and data are driven only while a request is open, so they are zero during reset
    // and stay stable for the whole request.
    assign bus.mem_addr  = bus.mem_req ? addr_q : '0;
    assign bus.mem_size  = bus.mem_req ? (dword_q ? 2'd3 : 2'd2) : 2'd0;
    assign bus.mem_wdata = bus.mem_we ? new_q : '0;
    assign bus.lr_addr   = addr_q;
    assign bus.sc_addr   = addr_q;
    assign bus.result    = result_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= OP_ADD;
            dword_q  <= 1'b0;
            mis_q    <= 1'b0;
            addr_q   <= '0;
            src_q    <= '0;
            result_q <= '0;
            new_q    <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.start) begin
                    op_q    <= op_dec;
                    dword_q <= dword_in;
                    addr_q  <= bus.addr;
                    src_q   <= bus.src;
                    mis_q   <= align_err;
                    if (align_err) result_q <= '0;
                end
                S_READ:    if (bus.mem_ready) result_q <= ld_val;
                S_COMPUTE: new_q <= store_fmt(dword_q, alu);
                S_SC_CHECK: begin
                    result_q <= XLEN'(!bus.sc_success);
                    new_q    <= store_fmt(dword_q, src_q);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_atomic_unit.sv
// Randomized scoreboard bench for atomic_unit (XLEN=64). A behavioural memory/AMO model predicts
// each response, and a monitor compares it when done pulses.
module tb_atomic_unit;
    localparam int XLEN = 64;
    localparam logic [4:0] F_ADD = 5'b00000, F_SWAP = 5'b00001, F_LR = 5'b00010, F_SC = 5'b00011;
    localparam logic [4:0] F_XOR = 5'b00100, F_OR = 5'b01000, F_AND = 5'b01100, F_MIN = 5'b10000;
    localparam logic [4:0] F_MAX = 5'b10100, F_MINU = 5'b11000, F_MAXU = 5'b11100;

    typedef struct {
        logic [63:0] result;
        logic        mis;
        logic        wr;
        logic [63:0] waddr;
        logic [63:0] wdata;
        logic        dw;
        int          lat;
        int          nreq;
        int          lr_n;
        int          sc_n;
        int          start_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0, miscompares = 0, cyc = 0;

    exp_t        exp_q[$];
    logic [63:0] dut_mem[logic [63:0]];
    logic [63:0] ref_mem[logic [63:0]];

    int          rd_wait = 0, wr_wait = 0;
    bit          sc_ok = 1'b0;
    logic [1:0]  exp_size = 2'd2;
    logic [63:0] cur_addr = '0;

    int          waits_total = 0, req_cnt = 0, lr_cnt = 0, sc_cnt = 0;
    bit          act_wr = 1'b0;
    logic [63:0] act_waddr = '0, act_wdata = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    atomic_unit_if #(.XLEN(XLEN)) bus ();
    atomic_unit #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    assign bus.sc_success = sc_ok;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_result"}, bus.result, 0);
        check({tag, "_misaligned"}, bus.misaligned, 0);
        check({tag, "_mem_req"}, bus.mem_req, 0);
        check({tag, "_mem_we"}, bus.mem_we, 0);
        check({tag, "_mem_addr"}, bus.mem_addr, 0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        check({tag, "_mem_size"}, bus.mem_size, 0);
        check({tag, "_lr_valid"}, bus.lr_valid, 0);
        check({tag, "_sc_valid"}, bus.sc_valid, 0);
        check({tag, "_lr_addr"}, bus.lr_addr, 0);
        check({tag, "_sc_addr"}, bus.sc_addr, 0);
    endtask

    task automatic clear_logs();
        waits_total = 0; req_cnt = 0; lr_cnt = 0; sc_cnt = 0; act_wr = 1'b0;
    endtask

    task automatic preload(input logic [63:0] a, input logic [63:0] v);
        dut_mem[a] = v;
        ref_mem[a] = v;
    endtask

    // Reference model: the architectural effect of one atomic on the model memory.
    function automatic exp_t model(input logic [4:0] f, input logic dw, input logic [63:0] a,
                                   input logic [63:0] s, input bit ok);
        exp_t e;
        logic [63:0] m, old, nv;
        logic [31:0] n32;
        longint so, ss;
        longint unsigned uo, us;
        int wo, ws;
        int unsigned uwo, uws;
        e = '{default: 0};
        e.dw = dw;
        if ((dw && a[2:0] != 3'd0) || (!dw && a[1:0] != 2'd0)) begin
            e.mis = 1'b1; e.lat = 1;
            return e;
        end
        m = ref_mem.exists(a) ? ref_mem[a] : 64'h0;
        if (f == F_SC) begin
            e.sc_n = 1;
            if (ok) begin
                e.wr = 1'b1; e.waddr = a; e.wdata = dw ? s : {32'h0, s[31:0]};
                e.lat = 3; e.nreq = 1;
                ref_mem[a] = dw ? s : {m[63:32], s[31:0]};
            end else begin
                e.result = 64'd1; e.lat = 2;
            end
            return e;
        end
        old = dw ? m : {{32{m[31]}}, m[31:0]};
        e.result = old;
        if (f == F_LR) begin
            e.lr_n = 1; e.lat = 2; e.nreq = 1;
            return e;
        end
        if (dw) begin
            so = old; ss = s; uo = old; us = s;
            case (f)
                F_SWAP:  nv = s;
                F_XOR:   nv = old ^ s;
                F_OR:    nv = old | s;
                F_AND:   nv = old & s;
                F_MIN:   nv = (so < ss) ? old : s;
                F_MAX:   nv = (so > ss) ? old : s;
                F_MINU:  nv = (uo < us) ? old : s;
                F_MAXU:  nv = (uo > us) ? old : s;
                default: nv = old + s;
            endcase
        end else begin
            wo = m[31:0]; ws = s[31:0]; uwo = m[31:0]; uws = s[31:0];
            case (f)
                F_SWAP:  n32 = s[31:0];
                F_XOR:   n32 = m[31:0] ^ s[31:0];
                F_OR:    n32 = m[31:0] | s[31:0];
                F_AND:   n32 = m[31:0] & s[31:0];
                F_MIN:   n32 = (wo < ws) ? m[31:0] : s[31:0];
                F_MAX:   n32 = (wo > ws) ? m[31:0] : s[31:0];
                F_MINU:  n32 = (uwo < uws) ? m[31:0] : s[31:0];
                F_MAXU:  n32 = (uwo > uws) ? m[31:0] : s[31:0];
                default: n32 = m[31:0] + s[31:0];
            endcase
            nv = {32'h0, n32};
        end
        e.wr = 1'b1; e.waddr = a; e.wdata = nv; e.lat = 4; e.nreq = 2;
        ref_mem[a] = dw ? nv : {m[63:32], nv[31:0]};
        return e;
    endfunction

    task automatic issue(input logic [4:0] f, input logic dw, input logic [63:0] a, input logic [63:0] s,
                         input bit ok, input int rw, input int ww);
        exp_t e;
        int guard = 0;
        @(posedge clk); #1;
        while (bus.busy && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (bus.busy) begin
            vectors++; miscompares++;
            $display("FAIL idle_timeout: busy=%0b after %0d cycles, expected 0", bus.busy, guard);
            return;
        end
        rd_wait = rw; wr_wait = ww; sc_ok = ok; exp_size = dw ? 2'd3 : 2'd2; cur_addr = a;
        e = model(f, dw, a, s, ok);
        e.start_cyc = cyc;
        exp_q.push_back(e);
        bus.start = 1'b1; bus.funct5 = f; bus.is_dword = dw; bus.addr = a; bus.src = s;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.funct5 = 5'($urandom());
        bus.is_dword = 1'($urandom());
        bus.addr = {32'($urandom()), 32'($urandom())};
        bus.src = {32'($urandom()), 32'($urandom())};
    endtask

    // Memory responder: answers after the configured number of wait cycles and checks that the
    // request stays stable while it waits.
    initial begin
        bit          in_req;
        int          cnt;
        logic [63:0] q_addr, q_wdata;
        logic        q_we;
        logic [1:0]  q_size;
        in_req = 1'b0; cnt = 0;
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (in_req && bus.mem_ready) in_req = 1'b0;
            bus.mem_ready = 1'b0;
            if (!bus.mem_req) begin
                in_req = 1'b0;
            end else begin
                if (!in_req) begin
                    in_req = 1'b1; cnt = 0;
                    q_addr = bus.mem_addr; q_we = bus.mem_we; q_wdata = bus.mem_wdata; q_size = bus.mem_size;
                    check("req_addr", bus.mem_addr, cur_addr);
                    check("req_size", bus.mem_size, exp_size);
                end else begin
                    cnt++;
                    check("hold_addr", bus.mem_addr, q_addr);
                    check("hold_we", bus.mem_we, q_we);
                    check("hold_size", bus.mem_size, q_size);
                    if (q_we) check("hold_wdata", bus.mem_wdata, q_wdata);
                end
                if (cnt >= (q_we ? wr_wait : rd_wait)) begin
                    bus.mem_ready = 1'b1;
                    waits_total += cnt;
                    req_cnt++;
                    if (q_we) begin
                        act_wr = 1'b1; act_waddr = q_addr; act_wdata = q_wdata;
                        dut_mem[q_addr] = (q_size == 2'd3) ? q_wdata : {dut_mem[q_addr][63:32], q_wdata[31:0]};
                    end else begin
                        bus.mem_rdata = (q_size == 2'd3) ? dut_mem[q_addr]
                                                         : {32'($urandom()), dut_mem[q_addr][31:0]};
                    end
                end
            end
        end
    end

    // Monitor: counts tracker pulses and scores each completion against the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.lr_valid) begin
                lr_cnt++;
                check("lr_addr", bus.lr_addr, cur_addr);
                check("lr_with_ready", bus.mem_ready, 1);
            end
            if (bus.sc_valid) begin
                sc_cnt++;
                check("sc_addr", bus.sc_addr, cur_addr);
            end
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_done: done=1 with %0d responses outstanding, expected none", exp_q.size());
                end else begin
                    e = exp_q.pop_front();
                    check("result", bus.result, e.result);
                    check("misaligned", bus.misaligned, e.mis);
                    check("latency", cyc - e.start_cyc, e.lat + waits_total);
                    check("mem_requests", req_cnt, e.nreq);
                    check("write_seen", act_wr, e.wr);
                    if (e.wr && act_wr) begin
                        check("write_addr", act_waddr, e.waddr);
                        check("write_data", e.dw ? act_wdata : {32'h0, act_wdata[31:0]}, e.wdata);
                    end
                    check("lr_pulses", lr_cnt, e.lr_n);
                    check("sc_pulses", sc_cnt, e.sc_n);
                end
                clear_logs();
            end
        end
    end

    initial begin
        logic [4:0]  f;
        logic        dw;
        logic [63:0] a, s, saved;
        int          guard;
        bus.start = 1'b0; bus.funct5 = '0; bus.is_dword = 1'b0; bus.addr = '0; bus.src = '0;
        for (int i = 0; i < 32; i++) preload(64'h1000 + 64'(4 * i), {32'($urandom()), 32'($urandom())});
        preload(64'h100, 64'hA5A5_A5A5_8000_0000);
        preload(64'h200, 64'h0000_0000_7FFF_FFFF);
        preload(64'h300, 64'h0000_0000_FFFF_FFFF);
        preload(64'h308, 64'h0000_0000_FFFF_FFFF);
        preload(64'h400, 64'h0123_4567_89AB_CDEF);
        preload(64'h500, 64'hFEDC_BA98_7654_3210);

        #2 reset = 1'b1;
        #1 check_zero("por");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        issue(F_LR, 1'b0, 64'h100, 64'h0, 1'b0, 0, 0);
        issue(F_SC, 1'b0, 64'h100, 64'h55, 1'b1, 0, 0);
        issue(F_SC, 1'b0, 64'h100, 64'h55, 1'b0, 0, 0);
        issue(F_ADD, 1'b0, 64'h200, 64'h1, 1'b0, 0, 0);
        issue(F_MINU, 1'b0, 64'h300, 64'h1, 1'b0, 0, 0);
        issue(F_MIN, 1'b0, 64'h308, 64'h1, 1'b0, 0, 0);
        issue(F_SWAP, 1'b1, 64'h500, 64'hDEAD_BEEF_0123_4567, 1'b0, 3, 3);
        issue(F_OR, 1'b0, 64'h102, 64'h5, 1'b0, 0, 0);

        // Reset while the write of an AMO is still waiting on mem_ready.
        saved = ref_mem[64'h400];
        issue(F_SWAP, 1'b1, 64'h400, 64'h0BAD_F00D_0BAD_F00D, 1'b0, 0, 20);
        guard = 0;
        while (!(bus.mem_req && bus.mem_we) && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("reached_write", bus.mem_we, 1);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        #1 check_zero("mid_write");
        exp_q.delete();
        ref_mem[64'h400] = saved;
        clear_logs();
        @(negedge clk);
        reset = 1'b0;
        issue(F_SWAP, 1'b1, 64'h400, 64'h1111_2222_3333_4444, 1'b0, 0, 0);

        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 11))
                0: f = F_ADD;   1: f = F_SWAP; 2: f = F_LR;   3: f = F_SC;
                4: f = F_XOR;   5: f = F_OR;   6: f = F_AND;  7: f = F_MIN;
                8: f = F_MAX;   9: f = F_MINU; 10: f = F_MAXU;
                default: f = 5'($urandom());
            endcase
            dw = 1'($urandom());
            a = 64'h1000 + 64'(8 * $urandom_range(0, 15)) + (dw ? 64'h0 : 64'(4 * $urandom_range(0, 1)));
            if ($urandom_range(0, 7) == 0) a = a + 64'($urandom_range(1, 3));
            case ($urandom_range(0, 3))
                0: s = 64'h0000_0000_7FFF_FFFF;
                1: s = 64'hFFFF_FFFF_8000_0000;
                2: s = 64'($urandom_range(0, 3));
                default: s = {32'($urandom()), 32'($urandom())};
            endcase
            issue(f, dw, a, s, 1'($urandom()), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 1000) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            vectors++; miscompares++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
